median_filter_3x3: RTL and testbench

//   3x3 median filter, directly downstream of the 3x3 window generator.
//   - Consumes the nine window pixels p11..p33 plus their vsync/href each clock.
//   - Emits one median pixel per valid window through a 3-stage compare pipeline.
//   - Delays vsync/href to stay aligned with the output data.

---
 rtl/median_filter_3x3.sv | 190 +++++++++++++++++++
 tb/tb_median_filter_3x3.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/median_filter_3x3.sv
// 3x3 median filter placed after the window generator.
// Each stage sorts three values at a time: row sort, then column reduce, then final pick.
// Data, href and vsync each pass through three register stages, so the latency is 3 clk.
// Optional build macro MEDIAN_BORDER_ZERO_EN zeroes the windows that touch the image border.
module median_filter_3x3 #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  matrix_frame_vsync,
  input  logic                  matrix_frame_href,
  input  logic [DATA_WIDTH-1:0] matrix_p11,
  input  logic [DATA_WIDTH-1:0] matrix_p12,
  input  logic [DATA_WIDTH-1:0] matrix_p13,
  input  logic [DATA_WIDTH-1:0] matrix_p21,
  input  logic [DATA_WIDTH-1:0] matrix_p22,
  input  logic [DATA_WIDTH-1:0] matrix_p23,
  input  logic [DATA_WIDTH-1:0] matrix_p31,
  input  logic [DATA_WIDTH-1:0] matrix_p32,
  input  logic [DATA_WIDTH-1:0] matrix_p33,
  output logic                  post_frame_vsync,
  output logic                  post_frame_href,
  output logic [DATA_WIDTH-1:0] post_img_y
);

  typedef logic [DATA_WIDTH-1:0] pix_t;

  // An image without an interior pixel has no meaningful median window.
  if (IMG_WIDTH < 3 || IMG_HEIGHT < 3) begin : g_size_check
    $error("median_filter_3x3: IMG_WIDTH and IMG_HEIGHT must be at least 3");
  end

  // Unsigned three-way compares; on a tie the lower-index operand is returned.
  function automatic pix_t max3(input pix_t a, input pix_t b, input pix_t c);
    pix_t m;
    m = (a >= b) ? a : b;
    return (m >= c) ? m : c;
  endfunction

  function automatic pix_t min3(input pix_t a, input pix_t b, input pix_t c);
    pix_t m;
    m = (b >= a) ? a : b;
    return (c >= m) ? m : c;
  endfunction

  function automatic pix_t mid3(input pix_t a, input pix_t b, input pix_t c);
    pix_t r;
    if ((a >= b && c >= a) || (a >= c && b >= a))
      r = a;
    else if ((b >= a && c >= b) || (b >= c && a >= b))
      r = b;
    else
      r = c;
    return r;
  endfunction

  pix_t row_a [3];
  pix_t row_b [3];
  pix_t row_c [3];

  pix_t max_p1 [3];
  pix_t mid_p1 [3];
  pix_t min_p1 [3];
  logic href_p1;
  logic vsync_p1;

  pix_t max_of_min_p2;
  pix_t mid_of_mid_p2;
  pix_t min_of_max_p2;
  logic href_p2;
  logic vsync_p2;

  logic zero_p2;

  // Gather the window rows so that stage 1 can loop over them.
  always_comb begin
    row_a[0] = matrix_p11; row_b[0] = matrix_p12; row_c[0] = matrix_p13;
    row_a[1] = matrix_p21; row_b[1] = matrix_p22; row_c[1] = matrix_p23;
    row_a[2] = matrix_p31; row_b[2] = matrix_p32; row_c[2] = matrix_p33;
  end

  // ---- stage 1: sort each row into max / mid / min ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      href_p1  <= 1'b0;
      vsync_p1 <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        max_p1[r] <= '0;
        mid_p1[r] <= '0;
        min_p1[r] <= '0;
      end
    end else begin
      href_p1  <= matrix_frame_href;
      vsync_p1 <= matrix_frame_vsync;
      for (int r = 0; r < 3; r++) begin
        max_p1[r] <= matrix_frame_href ? max3(row_a[r], row_b[r], row_c[r]) : '0;
        mid_p1[r] <= matrix_frame_href ? mid3(row_a[r], row_b[r], row_c[r]) : '0;
        min_p1[r] <= matrix_frame_href ? min3(row_a[r], row_b[r], row_c[r]) : '0;
      end
    end
  end

  // ---- stage 2: reduce the columns of the row-sorted window ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      href_p2       <= 1'b0;
      vsync_p2      <= 1'b0;
      max_of_min_p2 <= '0;
      mid_of_mid_p2 <= '0;
      min_of_max_p2 <= '0;
    end else begin
      href_p2       <= href_p1;
      vsync_p2      <= vsync_p1;
      max_of_min_p2 <= href_p1 ? max3(min_p1[0], min_p1[1], min_p1[2]) : '0;
      mid_of_mid_p2 <= href_p1 ? mid3(mid_p1[0], mid_p1[1], mid_p1[2]) : '0;
      min_of_max_p2 <= href_p1 ? min3(max_p1[0], max_p1[1], max_p1[2]) : '0;
    end
  end

  // ---- stage 3: the final median of the three candidates ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      post_frame_href  <= 1'b0;
      post_frame_vsync <= 1'b0;
      post_img_y       <= '0;
    end else begin
      post_frame_href  <= href_p2;
      post_frame_vsync <= vsync_p2;
      post_img_y       <= (href_p2 && !zero_p2) ?
                          mid3(max_of_min_p2, mid_of_mid_p2, min_of_max_p2) : '0;
    end
  end

`ifdef MEDIAN_BORDER_ZERO_EN
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic          href_prev;
  logic          vsync_prev;
  logic          border_now;
  logic          border_p1;

  // The counters give the position of the window that is presented in the current cycle.
  assign border_now = matrix_frame_href &&
                      (col_cnt == '0 || col_cnt == COL_LAST ||
                       row_cnt == '0 || row_cnt == ROW_LAST);

  // Track the column and row of the window; both counters saturate on the last index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt    <= '0;
      row_cnt    <= '0;
      href_prev  <= 1'b0;
      vsync_prev <= 1'b0;
    end else begin
      href_prev  <= matrix_frame_href;
      vsync_prev <= matrix_frame_vsync;
      if (matrix_frame_href) begin
        if (col_cnt != COL_LAST) col_cnt <= col_cnt + 1'b1;
      end else begin
        col_cnt <= '0;
      end
      if (matrix_frame_vsync && !vsync_prev)
        row_cnt <= '0;
      else if (href_prev && !matrix_frame_href && row_cnt != ROW_LAST)
        row_cnt <= row_cnt + 1'b1;
    end
  end

  // Delay the border flag so that it reaches stage 3 together with its window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      border_p1 <= 1'b0;
      zero_p2   <= 1'b0;
    end else begin
      border_p1 <= border_now;
      zero_p2   <= border_p1;
    end
  end
`else
  assign zero_p2 = 1'b0;
`endif

endmodule

// File: tb/tb_median_filter_3x3.sv
// Scoreboard bench for median_filter_3x3: the stimulus pushes the cycle-exact expected outputs into a queue
// and a monitor on the falling edge compares them with the DUT outputs.
// When MEDIAN_BORDER_ZERO_EN is defined, the expected values also follow the border rule for an 8x4 image.
module tb_median_filter_3x3;
  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          vs, hr;
  logic [DW-1:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
  logic          post_frame_vsync, post_frame_href;
  logic [DW-1:0] post_img_y;

  always #5 clk = ~clk;

  median_filter_3x3 #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst),
    .matrix_frame_vsync(vs), .matrix_frame_href(hr),
    .matrix_p11(p11), .matrix_p12(p12), .matrix_p13(p13),
    .matrix_p21(p21), .matrix_p22(p22), .matrix_p23(p23),
    .matrix_p31(p31), .matrix_p32(p32), .matrix_p33(p33),
    .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
    .post_img_y(post_img_y)
  );

  typedef struct {
    int       due;
    int       tag;
    logic     vs;
    logic     hr;
    logic [7:0] y;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic cur_vs = 1'b0;

`ifdef MEDIAN_BORDER_ZERO_EN
  int   m_col = 0;
  int   m_row = 0;
  logic m_prev_hr = 1'b0;
  logic m_prev_vs = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [71:0] win9(input logic [7:0] a, b, c, d, e, f, g, h, i);
    return {a, b, c, d, e, f, g, h, i};
  endfunction

  task automatic push_exp(input int tag, input logic v, input logic h, input logic [7:0] y);
    exp_t e;
    e.due = cyc + 3; e.tag = tag; e.vs = v; e.hr = h; e.y = h ? y : 8'h00;
    q.push_back(e);
  endtask

  // One clock of stimulus; y_hand is the hand-computed median of w.
  task automatic drive(input int tag, input logic v, input logic h,
                       input logic [71:0] w, input logic [7:0] y_hand);
    logic border;
    @(posedge clk); #1;
    vs = v; hr = h;
    {p11, p12, p13, p21, p22, p23, p31, p32, p33} = w;
    border = 1'b0;
`ifdef MEDIAN_BORDER_ZERO_EN
    border = h && (m_col == 0 || m_col == W - 1 || m_row == 0 || m_row == H - 1);
    if (v && !m_prev_vs) m_row = 0;
    else if (m_prev_hr && !h && m_row < H - 1) m_row = m_row + 1;
    m_col = h ? ((m_col < W - 1) ? m_col + 1 : m_col) : 0;
    m_prev_hr = h; m_prev_vs = v;
`endif
    push_exp(tag, v, h, border ? 8'h00 : y_hand);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, cur_vs, 1'b0, 72'h0, 8'h00);
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Monitor: every cycle, compare the DUT outputs with the entry due in this cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      if (q[0].due < cyc) begin
        mon_e = q.pop_front();
        checks++; failures++;
        $display("FAIL sb_missed tag=%0d due=%0d now=%0d", mon_e.tag, mon_e.due, cyc);
      end else if (q[0].due == cyc) begin
        mon_e = q.pop_front();
        checks++;
        if ({post_frame_vsync, post_frame_href, post_img_y} !== {mon_e.vs, mon_e.hr, mon_e.y}) begin
          failures++;
          $display("FAIL sb_t%0d cyc=%0d got vs=%b href=%b y=%h want vs=%b href=%b y=%h",
                   mon_e.tag, cyc, post_frame_vsync, post_frame_href, post_img_y,
                   mon_e.vs, mon_e.hr, mon_e.y);
        end
      end
    end
  end

  initial begin
    vs = 1'b0; hr = 1'b0;
    {p11, p12, p13, p21, p22, p23, p31, p32, p33} = 72'h0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_y", post_img_y, 8'h00);
    chk("reset_href", {7'h0, post_frame_href}, 8'h00);
    chk("reset_vsync", {7'h0, post_frame_vsync}, 8'h00);
    @(posedge clk); #1 rst = 1'b0;
    idle(4);

    // Test 1: a constant line of 640 windows
    for (int k = 0; k < 640; k++) drive(1, 1'b0, 1'b1, {9{8'h80}}, 8'h80);
    idle(2);

    // Test 2: bright and dark impulses on the centre pixel
    drive(2, 1'b0, 1'b1, win9(8'h10, 8'h10, 8'h10, 8'h10, 8'hFF, 8'h10, 8'h10, 8'h10, 8'h10), 8'h10);
    drive(2, 1'b0, 1'b1, win9(8'h10, 8'h10, 8'h10, 8'h10, 8'h00, 8'h10, 8'h10, 8'h10, 8'h10), 8'h10);
    // Test 3: distinct values, then ties
    drive(3, 1'b0, 1'b1, win9(8'd9, 8'd1, 8'd5, 8'd7, 8'd3, 8'd8, 8'd2, 8'd6, 8'd4), 8'd5);
    drive(3, 1'b0, 1'b1, win9(8'd4, 8'd4, 8'd4, 8'd1, 8'd1, 8'd9, 8'd9, 8'd9, 8'd1), 8'd4);
    drive(3, 1'b0, 1'b1, win9(8'd200, 8'd10, 8'd90, 8'd30, 8'd250, 8'd60, 8'd70, 8'd80, 8'd5), 8'd70);
    idle(2);

    // Test 4: href pattern 1,1,0,1 with the vsync edges
    drive(4, 1'b1, 1'b1, {9{8'h20}}, 8'h20);
    drive(4, 1'b1, 1'b1, {9{8'h30}}, 8'h30);
    drive(4, 1'b1, 1'b0, {9{8'h77}}, 8'h00);
    drive(4, 1'b0, 1'b1, {9{8'h40}}, 8'h40);
    cur_vs = 1'b0;
    idle(3);

    // Test 5: a reset while 8'h55 windows are still in the pipeline
    drive(5, 1'b0, 1'b1, {9{8'h55}}, 8'h55);
    drive(5, 1'b0, 1'b1, {9{8'h55}}, 8'h55);
    @(posedge clk); #1;
    rst = 1'b1; vs = 1'b0; hr = 1'b0;
    {p11, p12, p13, p21, p22, p23, p31, p32, p33} = 72'h0;
    foreach (q[i]) begin q[i].vs = 1'b0; q[i].hr = 1'b0; q[i].y = 8'h00; end
    push_exp(5, 1'b0, 1'b0, 8'h00);
    #1;
    chk("midrst_y", post_img_y, 8'h00);
    chk("midrst_href", {7'h0, post_frame_href}, 8'h00);
`ifdef MEDIAN_BORDER_ZERO_EN
    m_col = 0; m_row = 0; m_prev_hr = 1'b0; m_prev_vs = 1'b0;
`endif
    @(posedge clk); #1 rst = 1'b0;
    push_exp(5, 1'b0, 1'b0, 8'h00);
    idle(5);
    drive(5, 1'b0, 1'b1, {9{8'h66}}, 8'h66);
    drive(5, 1'b0, 1'b1, {9{8'h66}}, 8'h66);
    idle(4);

    // Test 6: an 8x4 frame with a constant value of 8'h80
    cur_vs = 1'b1;
    idle(2);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) drive(6, 1'b1, 1'b1, {9{8'h80}}, 8'h80);
      idle(2);
    end
    cur_vs = 1'b0;
    idle(4);

    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      checks++; failures++;
      $display("FAIL sb_drain pending=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
